// File: rtl/crc_stream_checker.sv
// Streaming CRC frame checker; CRC_STREAM_LEN_CHECK_EN adds length counting and framing-error checks.
// Latency: o_done pulses the cycle after the i_last beat is accepted; one beat per cycle.
// Backpressure: o_ready drops only in the single DONE cycle; an unaccepted beat must be held by the source.
module crc_stream_checker #(
    parameter int                   DATA_BYTES = 1,
    parameter int                   CRC_WIDTH  = 8,
    parameter logic [CRC_WIDTH-1:0] POLY       = CRC_WIDTH'('h07),
    parameter logic [CRC_WIDTH-1:0] INIT       = CRC_WIDTH'('h0D),
    parameter int                   MAX_BYTES  = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_valid,
    input  logic                           i_last,
    input  logic [8*DATA_BYTES-1:0]        i_data,
    input  logic [DATA_BYTES-1:0]          i_keep,
    output logic                           o_ready,
    output logic                           o_done,
    output logic                           o_match,
    output logic [CRC_WIDTH-1:0]           o_crc,
    output logic [$clog2(MAX_BYTES+1)-1:0] o_len,
    output logic                           o_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CRC_WIDTH-1:0]   crc_q, crc_d;
    logic [CRC_WIDTH-1:0]   res_crc_q, res_crc_d;
    logic                   res_match_q, res_match_d;

    logic                   accept;
    logic                   first_beat;
    logic                   frame_end;
    logic                   frame_err;
    logic [DATA_BYTES-1:0]  keep_eff;
    logic [CRC_WIDTH-1:0]   crc_beat;

    function automatic logic [CRC_WIDTH-1:0] fold_byte(input logic [CRC_WIDTH-1:0] c,
                                                       input logic [7:0]           b);
        logic [CRC_WIDTH-1:0] r;
        r = c ^ (CRC_WIDTH'(b) << (CRC_WIDTH - 8));
        for (int k = 0; k < 8; k++) begin
            if (r[CRC_WIDTH-1]) begin
                r = (r << 1) ^ POLY;
            end else begin
                r = r << 1;
            end
        end
        return r;
    endfunction

    assign o_ready    = (state_q != ST_DONE);
    assign o_done     = (state_q == ST_DONE);
    assign accept     = i_valid && o_ready;
    assign first_beat = accept && (state_q == ST_IDLE);
    assign frame_end  = accept && i_last;

    // A new frame folds from INIT directly, so a frame may start in the cycle right after DONE.
    always_comb begin : beat_fold
        keep_eff = i_last ? i_keep : '1;
        crc_beat = (state_q == ST_IDLE) ? INIT : crc_q;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (keep_eff[i]) begin
                crc_beat = fold_byte(crc_beat, i_data[8*i +: 8]);
            end
        end
    end

    always_comb begin : fsm_next
        state_d = state_q;
        crc_d   = crc_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = i_last ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                if (frame_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (accept) begin
            crc_d = crc_beat;
        end else if (state_q == ST_DONE) begin
            crc_d = INIT;
        end
    end

    // Results load on entry to DONE and clear when the next frame's first beat lands.
    always_comb begin : result_next
        res_crc_d   = res_crc_q;
        res_match_d = res_match_q;
        if (frame_end) begin
            res_crc_d   = crc_beat;
            res_match_d = (crc_beat == '0) && !frame_err;
        end else if (first_beat) begin
            res_crc_d   = INIT;
            res_match_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            crc_q       <= INIT;
            res_crc_q   <= INIT;
            res_match_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            res_crc_q   <= res_crc_d;
            res_match_q <= res_match_d;
        end
    end

    assign o_crc   = res_crc_q;
    assign o_match = res_match_q;

`ifdef CRC_STREAM_LEN_CHECK_EN
    localparam int               LEN_W   = $clog2(MAX_BYTES + 1);
    localparam int               SUM_W   = LEN_W + 4;
    localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'(MAX_BYTES);
    localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(CRC_WIDTH / 8 + 1);

    logic [LEN_W-1:0] len_q, len_d, len_next;
    logic             ovf_q, ovf_d, ovf_next;
    logic [LEN_W-1:0] res_len_q, res_len_d;
    logic             res_err_q, res_err_d;
    logic [3:0]       beat_bytes;
    logic [SUM_W-1:0] len_sum;

    // Length saturates at MAX_BYTES but the overflow is remembered until the frame closes.
    always_comb begin : len_track
        beat_bytes = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (keep_eff[i]) begin
                beat_bytes = beat_bytes + 4'd1;
            end
        end
        len_sum  = (state_q == ST_IDLE) ? '0 : SUM_W'(len_q);
        len_sum  = len_sum + SUM_W'(beat_bytes);
        ovf_next = (state_q != ST_IDLE) && ovf_q;
        len_next = len_sum[LEN_W-1:0];
        if (len_sum > MAX_SUM) begin
            ovf_next = 1'b1;
            len_next = LEN_W'(MAX_BYTES);
        end
        frame_err = ovf_next || (len_next < MIN_LEN) || (i_keep == '0);

        len_d     = len_q;
        ovf_d     = ovf_q;
        res_len_d = res_len_q;
        res_err_d = res_err_q;
        if (accept) begin
            len_d = len_next;
            ovf_d = ovf_next;
        end else if (state_q == ST_DONE) begin
            len_d = '0;
            ovf_d = 1'b0;
        end
        if (frame_end) begin
            res_len_d = len_next;
            res_err_d = frame_err;
        end else if (first_beat) begin
            res_len_d = '0;
            res_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q     <= '0;
            ovf_q     <= 1'b0;
            res_len_q <= '0;
            res_err_q <= 1'b0;
        end else begin
            len_q     <= len_d;
            ovf_q     <= ovf_d;
            res_len_q <= res_len_d;
            res_err_q <= res_err_d;
        end
    end

    assign o_len = res_len_q;
    assign o_err = res_err_q;
`else
    assign frame_err = 1'b0;
    assign o_len     = '0;
    assign o_err     = 1'b0;
`endif

endmodule

// File: tb/tb_crc_stream_checker.sv
// Scoreboard bench for crc_stream_checker: three configurations (1/4/2 bytes per beat, CRC-8 and CRC-16),
// directed frames with hand-computed residues; a negedge monitor per instance pops expectations on o_done.
module tb_crc_stream_checker;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;
    int acc_cyc     = 0;

`ifdef CRC_STREAM_LEN_CHECK_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] crc;
        logic        match;
        logic [7:0]  len;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t       qa[$];
    exp_t       qb[$];
    exp_t       qc[$];
    logic [7:0] fbytes[$];

    // A: 1 byte/beat CRC-8, MAX 16
    logic       a_valid = 1'b0, a_last = 1'b0;
    logic [7:0] a_data  = '0;
    logic [0:0] a_keep  = '0;
    logic       a_ready, a_done, a_match, a_err;
    logic [7:0] a_crc;
    logic [4:0] a_len;
    // B: 4 bytes/beat CRC-8
    logic        b_valid = 1'b0, b_last = 1'b0;
    logic [31:0] b_data  = '0;
    logic [3:0]  b_keep  = '0;
    logic        b_ready, b_done, b_match, b_err;
    logic [7:0]  b_crc;
    logic [6:0]  b_len;
    // C: 2 bytes/beat CRC-16/CCITT
    logic        c_valid = 1'b0, c_last = 1'b0;
    logic [15:0] c_data  = '0;
    logic [1:0]  c_keep  = '0;
    logic        c_ready, c_done, c_match, c_err;
    logic [15:0] c_crc;
    logic [6:0]  c_len;

    crc_stream_checker #(.DATA_BYTES(1), .CRC_WIDTH(8), .POLY(8'h07), .INIT(8'h00), .MAX_BYTES(16)) u_a (
        .clk(clk), .reset(reset), .i_valid(a_valid), .i_last(a_last), .i_data(a_data), .i_keep(a_keep),
        .o_ready(a_ready), .o_done(a_done), .o_match(a_match), .o_crc(a_crc), .o_len(a_len), .o_err(a_err));

    crc_stream_checker #(.DATA_BYTES(4), .CRC_WIDTH(8), .POLY(8'h07), .INIT(8'h00), .MAX_BYTES(64)) u_b (
        .clk(clk), .reset(reset), .i_valid(b_valid), .i_last(b_last), .i_data(b_data), .i_keep(b_keep),
        .o_ready(b_ready), .o_done(b_done), .o_match(b_match), .o_crc(b_crc), .o_len(b_len), .o_err(b_err));

    crc_stream_checker #(.DATA_BYTES(2), .CRC_WIDTH(16), .POLY(16'h1021), .INIT(16'hFFFF), .MAX_BYTES(64)) u_c (
        .clk(clk), .reset(reset), .i_valid(c_valid), .i_last(c_last), .i_data(c_data), .i_keep(c_keep),
        .o_ready(c_ready), .o_done(c_done), .o_match(c_match), .o_crc(c_crc), .o_len(c_len), .o_err(c_err));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s", nm);
    endtask

    function automatic exp_t mk(input logic [15:0] crc, input logic [7:0] len, input logic err);
        exp_t e;
        e.crc   = crc;
        e.len   = LEN_EN ? len : 8'd0;
        e.err   = LEN_EN ? err : 1'b0;
        e.match = (crc == 16'h0) && !e.err;
        e.cyc   = acc_cyc;
        return e;
    endfunction

    task automatic check_res(input string tag, input exp_t e, input logic [15:0] crc, input logic m,
                             input logic [7:0] len, input logic err, input logic rdy);
        chk({tag, " crc"}, 32'(crc), 32'(e.crc));
        chk({tag, " match"}, 32'(m), 32'(e.match));
        chk({tag, " len"}, 32'(len), 32'(e.len));
        chk({tag, " err"}, 32'(err), 32'(e.err));
        chk({tag, " done_cycle"}, cyc, e.cyc);
        chk({tag, " ready_in_done"}, 32'(rdy), 32'd0);
    endtask

    always @(negedge clk) begin
        if (a_done === 1'b1) begin
            if (qa.size() == 0) fail_now("A spurious_done: o_done=1 with no frame outstanding");
            else check_res("A", qa.pop_front(), 16'(a_crc), a_match, 8'(a_len), a_err, a_ready);
        end
        if (b_done === 1'b1) begin
            if (qb.size() == 0) fail_now("B spurious_done: o_done=1 with no frame outstanding");
            else check_res("B", qb.pop_front(), 16'(b_crc), b_match, 8'(b_len), b_err, b_ready);
        end
        if (c_done === 1'b1) begin
            if (qc.size() == 0) fail_now("C spurious_done: o_done=1 with no frame outstanding");
            else check_res("C", qc.pop_front(), c_crc, c_match, 8'(c_len), c_err, c_ready);
        end
    end

    // Waits for o_ready at negedge, then lets the edge take the beat; bounded.
    task automatic wait_acc(input int which);
        bit   got;
        logic rdy;
        got = 1'b0;
        for (int n = 0; n < 32 && !got; n++) begin
            @(negedge clk);
            rdy = (which == 0) ? a_ready : (which == 1) ? b_ready : c_ready;
            if (rdy === 1'b1) begin
                @(posedge clk);
                #1;
                acc_cyc = cyc;
                got     = 1'b1;
            end
        end
        if (!got) fail_now($sformatf("accept_timeout instance %0d: o_ready never rose", which));
    endtask

    task automatic beat_a(input logic [7:0] d, input logic k, input logic l);
        a_valid = 1'b1; a_data = d; a_keep = k; a_last = l;
        wait_acc(0);
        a_valid = 1'b0; a_last = 1'b0;
    endtask

    task automatic beat_b(input logic [31:0] d, input logic [3:0] k, input logic l);
        b_valid = 1'b1; b_data = d; b_keep = k; b_last = l;
        wait_acc(1);
        b_valid = 1'b0; b_last = 1'b0;
    endtask

    task automatic beat_c(input logic [15:0] d, input logic [1:0] k, input logic l);
        c_valid = 1'b1; c_data = d; c_keep = k; c_last = l;
        wait_acc(2);
        c_valid = 1'b0; c_last = 1'b0;
    endtask

    task automatic frame_a(input bit empty_last, input logic [7:0] xcrc, input logic [7:0] xlen, input logic xerr);
        int n;
        n = fbytes.size();
        for (int i = 0; i < n; i++) begin
            beat_a(fbytes[i], 1'b1, (i == n - 1) && !empty_last);
            if (i == 0 && (n > 1 || empty_last)) begin
                chk("A clear_crc", 32'(a_crc), 32'h00);
                chk("A clear_match", 32'(a_match), 32'd0);
                chk("A clear_len", 32'(a_len), 32'd0);
            end
        end
        if (empty_last) beat_a(8'hA5, 1'b0, 1'b1);
        qa.push_back(mk(16'(xcrc), xlen, xerr));
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("A reset_ready", 32'(a_ready), 32'd1);
        chk("A reset_done", 32'(a_done), 32'd0);
        chk("A reset_crc", 32'(a_crc), 32'h00);
        chk("A reset_match", 32'(a_match), 32'd0);
        chk("A reset_len", 32'(a_len), 32'd0);
        chk("A reset_err", 32'(a_err), 32'd0);
        chk("B reset_ready", 32'(b_ready), 32'd1);
        chk("C reset_crc", 32'(c_crc), 32'hFFFF);
        chk("C reset_done", 32'(c_done), 32'd0);
        gap(1);

        // CRC-8 "123456789" = 0xF4; a 0xF5 trailer leaves residue table[0x01] = 0x07
        fbytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF5};
        frame_a(1'b0, 8'h07, 8'd10, 1'b0);
        gap(3);
        chk("A hold_crc", 32'(a_crc), 32'h07);
        chk("A hold_len", 32'(a_len), LEN_EN ? 32'd10 : 32'd0);
        chk("A hold_done", 32'(a_done), 32'd0);

        fbytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
        frame_a(1'b0, 8'h00, 8'd10, 1'b0);

        fbytes = '{8'h00};
        frame_a(1'b0, 8'h00, 8'd1, 1'b1);

        fbytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        frame_a(1'b0, 8'h00, 8'd16, 1'b1);

        fbytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
        frame_a(1'b1, 8'h00, 8'd10, 1'b1);

        // reset lands with the 5th beat on the bus
        gap(2);
        for (int i = 0; i < 4; i++) beat_a(fbytes[i], 1'b1, 1'b0);
        a_valid = 1'b1; a_data = fbytes[4]; a_keep = 1'b1; a_last = 1'b0; reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; a_valid = 1'b0;
        @(negedge clk);
        chk("A midreset_done", 32'(a_done), 32'd0);
        chk("A midreset_crc", 32'(a_crc), 32'h00);
        chk("A midreset_len", 32'(a_len), 32'd0);
        chk("A midreset_ready", 32'(a_ready), 32'd1);
        gap(1);
        frame_a(1'b0, 8'h00, 8'd10, 1'b0);

        // three back-to-back frames; third uses junk keep on non-last beats
        gap(2);
        beat_b(32'h34333231, 4'hF, 1'b0);
        t0 = acc_cyc;
        beat_b(32'h38373635, 4'hF, 1'b0);
        beat_b(32'h0000F439, 4'b0011, 1'b1);
        qb.push_back(mk(16'h0000, 8'd10, 1'b0));
        beat_b(32'h34333231, 4'hF, 1'b0);
        beat_b(32'h38373635, 4'hF, 1'b0);
        beat_b(32'h0000F539, 4'b0011, 1'b1);
        qb.push_back(mk(16'h0007, 8'd10, 1'b0));
        beat_b(32'h34333231, 4'h0, 1'b0);
        beat_b(32'h38373635, 4'h5, 1'b0);
        beat_b(32'hFFFFF439, 4'b0011, 1'b1);
        qb.push_back(mk(16'h0000, 8'd10, 1'b0));
        chk("B back_to_back_span", acc_cyc - t0, 32'd10);

        // CRC-16/CCITT-FALSE "123456789" = 0x29B1, beats with idle gaps
        gap(2);
        beat_c(16'h3231, 2'b11, 1'b0);
        gap(2);
        beat_c(16'h3433, 2'b11, 1'b0);
        beat_c(16'h3635, 2'b11, 1'b0);
        gap(1);
        beat_c(16'h3837, 2'b11, 1'b0);
        beat_c(16'h2939, 2'b11, 1'b0);
        gap(3);
        beat_c(16'h00B1, 2'b01, 1'b1);
        qc.push_back(mk(16'h0000, 8'd11, 1'b0));
        // 0xB0 instead of 0xB1 leaves residue 0x1021; reset asserted during its DONE cycle
        beat_c(16'h3231, 2'b11, 1'b0);
        beat_c(16'h3433, 2'b11, 1'b0);
        beat_c(16'h3635, 2'b11, 1'b0);
        beat_c(16'h3837, 2'b11, 1'b0);
        beat_c(16'h2939, 2'b11, 1'b0);
        beat_c(16'hEEB0, 2'b01, 1'b1);
        qc.push_back(mk(16'h1021, 8'd11, 1'b0));
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("C post_reset_done", 32'(c_done), 32'd0);
        chk("C post_reset_crc", 32'(c_crc), 32'hFFFF);
        chk("C post_reset_match", 32'(c_match), 32'd0);
        chk("C post_reset_ready", 32'(c_ready), 32'd1);

        gap(5);
        chk("A pending_frames", qa.size(), 32'd0);
        chk("B pending_frames", qb.size(), 32'd0);
        chk("C pending_frames", qc.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
